// File: rtl/impl_test_pkg.sv
// Shared sizing helpers for the implementation-test I/O bank and its XOR fold tree.
package impl_test_pkg;

    localparam int unsigned MAX_STAGES = 16;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Node count N_s of fold level s (level 0 is the raw result array).
    function automatic int unsigned stage_width(input int unsigned n, input int unsigned fanin,
                                                input int unsigned s);
        int unsigned w;
        w = n;
        for (int unsigned i = 0; i < s; i++) w = ceil_div(w, fanin);
        return w;
    endfunction

    // Number of registered levels; at least one even for a single result.
    function automatic int unsigned fold_stages(input int unsigned n, input int unsigned fanin);
        int unsigned w;
        int unsigned l;
        l = 1;
        w = ceil_div(n, fanin);
        while (w > 1 && l < MAX_STAGES) begin
            w = ceil_div(w, fanin);
            l++;
        end
        return l;
    endfunction

    // Element offset of level s inside the concatenated level bus.
    function automatic int unsigned level_offset(input int unsigned n, input int unsigned fanin,
                                                 input int unsigned s);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i < s; i++) off += stage_width(n, fanin, i);
        return off;
    endfunction

endpackage

// File: rtl/impl_test_io_bank_if.sv
// Bank-write, result and signature signals of the implementation-test I/O wrapper.
interface impl_test_io_bank_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned DEPTH      = 68,
    parameter int unsigned NUM_RES    = 52,
    parameter int unsigned ADDR_W     = 10
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                                 wr_en;
    logic [CH_W-1:0]                      wr_ch;
    logic [ADDR_W-1:0]                    wr_addr;
    logic [DATA_WIDTH-1:0]                wr_data;
    logic [NUM_CH*DEPTH*DATA_WIDTH-1:0]   bank_out;
    logic                                 addr_err;
    logic                                 res_valid;
    logic [NUM_RES*DATA_WIDTH-1:0]        res_data;
    logic                                 acc_mode;
    logic                                 sig_clear;
    logic                                 sig_valid;
    logic [DATA_WIDTH-1:0]                sig_out;
    logic [15:0]                          sig_count;

    modport master (
        output wr_en, wr_ch, wr_addr, wr_data, res_valid, res_data, acc_mode, sig_clear,
        input  bank_out, addr_err, sig_valid, sig_out, sig_count
    );

    modport slave (
        input  wr_en, wr_ch, wr_addr, wr_data, res_valid, res_data, acc_mode, sig_clear,
        output bank_out, addr_err, sig_valid, sig_out, sig_count
    );

endinterface

// File: rtl/xor_fold_stage.sv
// One registered XOR reduction level: groups of FANIN words fold into one, valid travels along.
module xor_fold_stage
    import impl_test_pkg::*;
#(
    parameter int unsigned N_IN       = 1,
    parameter int unsigned FANIN      = 5,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              valid_i,
    input  logic [N_IN*DATA_WIDTH-1:0]                        data_i,
    output logic                                              valid_o,
    output logic [ceil_div(N_IN, FANIN)*DATA_WIDTH-1:0]       data_o
);
    localparam int unsigned N_OUT = ceil_div(N_IN, FANIN);

    logic [N_OUT*DATA_WIDTH-1:0] data_d, data_q;
    logic                        valid_q;

    // Missing members of a partial group simply contribute nothing (zero).
    always_comb begin
        data_d = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            data_d[(i / FANIN) * DATA_WIDTH +: DATA_WIDTH] ^= data_i[i * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/impl_test_io_bank.sv
// Test I/O wrapper: addressed input register bank plus pipelined XOR signature of a result array.
module impl_test_io_bank
    import impl_test_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned DEPTH      = 68,
    parameter int unsigned NUM_RES    = 52,
    parameter int unsigned FANIN      = 5,
    parameter int unsigned ADDR_W     = 10
) (
    input logic               clk,
    input logic               rst_n,
    impl_test_io_bank_if.slave io
);
    localparam int unsigned BANK_W = NUM_CH * DEPTH * DATA_WIDTH;
    localparam int unsigned L      = fold_stages(NUM_RES, FANIN);
    localparam int unsigned TOTAL  = level_offset(NUM_RES, FANIN, L + 1);

    // ---------------- input bank ----------------
    logic [BANK_W-1:0] bank_d, bank_q;
    logic              wr_ok;
    logic              addr_err_d, addr_err_q;
    int unsigned       wr_off;

    always_comb begin
        wr_ok      = io.wr_en && (32'(io.wr_ch) < NUM_CH) && (32'(io.wr_addr) < DEPTH);
        addr_err_d = io.wr_en && !wr_ok;
        wr_off     = (32'(io.wr_ch) * DEPTH + 32'(io.wr_addr)) * DATA_WIDTH;
        bank_d     = bank_q;
        if (wr_ok) bank_d[wr_off +: DATA_WIDTH] = io.wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign io.bank_out = bank_q;
    assign io.addr_err = addr_err_q;

    // ---------------- fold tree ----------------
    // All levels share one bus; level s starts at element level_offset(s).
    logic [TOTAL*DATA_WIDTH-1:0] lvl_data;
    logic [L:0]                  lvl_valid;

    assign lvl_data[NUM_RES*DATA_WIDTH-1:0] = io.res_data;
    assign lvl_valid[0]                     = io.res_valid;

    for (genvar s = 0; s < L; s++) begin : g_stage
        localparam int unsigned N_IN    = stage_width(NUM_RES, FANIN, s);
        localparam int unsigned N_OUT   = stage_width(NUM_RES, FANIN, s + 1);
        localparam int unsigned IN_OFF  = level_offset(NUM_RES, FANIN, s) * DATA_WIDTH;
        localparam int unsigned OUT_OFF = level_offset(NUM_RES, FANIN, s + 1) * DATA_WIDTH;

        xor_fold_stage #(
            .N_IN      (N_IN),
            .FANIN     (FANIN),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .valid_i(lvl_valid[s]),
            .data_i (lvl_data[IN_OFF +: N_IN*DATA_WIDTH]),
            .valid_o(lvl_valid[s+1]),
            .data_o (lvl_data[OUT_OFF +: N_OUT*DATA_WIDTH])
        );
    end

    // ---------------- signature register ----------------
    logic [DATA_WIDTH-1:0] fold;
    logic                  fold_valid;
    logic [DATA_WIDTH-1:0] sig_d, sig_q;
    logic [15:0]           cnt_d, cnt_q;
    logic                  sig_valid_d, sig_valid_q;

    assign fold       = lvl_data[(TOTAL-1)*DATA_WIDTH +: DATA_WIDTH];
    assign fold_valid = lvl_valid[L];

    // A clear in the same cycle as a fold acts first, so the fold lands on a zero signature.
    always_comb begin
        sig_d       = sig_q;
        cnt_d       = cnt_q;
        sig_valid_d = 1'b0;
        if (io.sig_clear) begin
            sig_d = '0;
            cnt_d = '0;
        end
        if (fold_valid) begin
            sig_valid_d = 1'b1;
            if (io.acc_mode && !io.sig_clear) begin
                sig_d = ((sig_q << 1) | (sig_q >> (DATA_WIDTH - 1))) ^ fold;
            end else begin
                sig_d = fold;
            end
            if (io.sig_clear)            cnt_d = 16'd1;
            else if (cnt_q != 16'hFFFF)  cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q       <= '0;
            cnt_q       <= '0;
            sig_valid_q <= 1'b0;
        end else begin
            sig_q       <= sig_d;
            cnt_q       <= cnt_d;
            sig_valid_q <= sig_valid_d;
        end
    end

    assign io.sig_out   = sig_q;
    assign io.sig_count = cnt_q;
    assign io.sig_valid = sig_valid_q;

endmodule

// File: tb/tb_impl_test_io_bank.sv
// Directed bench for impl_test_io_bank with a signature scoreboard checked by a monitor.
module tb_impl_test_io_bank;
    localparam int unsigned DW   = 64;
    localparam int unsigned NCH  = 3;
    localparam int unsigned DEP  = 68;
    localparam int unsigned NRES = 52;
    localparam int unsigned FAN  = 5;
    localparam int unsigned AW   = 10;
    localparam int unsigned BW   = NCH * DEP * DW;
    localparam int unsigned LAT  = 4;

    typedef struct {
        logic [63:0] sig;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    impl_test_io_bank_if #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP), .NUM_RES(NRES), .ADDR_W(AW)
    ) io ();

    impl_test_io_bank #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP), .NUM_RES(NRES), .FANIN(FAN), .ADDR_W(AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    exp_t              sb[$];
    int                compared = 0;
    int                mismatched = 0;
    int                pcyc = 0;
    int                nvalid = 0;
    logic [63:0]       m_sig = '0;
    logic [15:0]       m_cnt = '0;
    logic [BW-1:0]     bank_m = '0;
    logic [NRES*DW-1:0] d;

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bank(input string tag);
        int bad = -1;
        for (int i = 0; i < int'(NCH * DEP); i++)
            if (bad < 0 && io.bank_out[i*DW +: DW] !== bank_m[i*DW +: DW]) bad = i;
        compared++;
        assert (io.bank_out === bank_m) else begin
            mismatched++;
            if (bad < 0) bad = 0;
            $error("FAIL %s: entry %0d observed %h expected %h", tag, bad,
                   io.bank_out[bad*DW +: DW], bank_m[bad*DW +: DW]);
        end
    endtask

    // Reference signature model, applied in the order results reach the signature stage.
    task automatic expect_sig(input logic [63:0] f, input logic acc, input logic clr,
                              input int cyc);
        exp_t e;
        if (clr) begin
            m_sig = '0;
            m_cnt = '0;
        end
        m_sig = acc ? ({m_sig[62:0], m_sig[63]} ^ f) : f;
        if (m_cnt != 16'hFFFF) m_cnt++;
        e.sig = m_sig;
        e.cnt = m_cnt;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] fold_ref(input logic [NRES*DW-1:0] v);
        logic [63:0] f = '0;
        for (int k = 0; k < int'(NRES); k++) f ^= v[k*DW +: DW];
        return f;
    endfunction

    task automatic bank_write(input int ch, input int addr, input logic [63:0] data);
        @(negedge clk);
        io.wr_en   = 1'b1;
        io.wr_ch   = 2'(ch);
        io.wr_addr = AW'(addr);
        io.wr_data = data;
        if (ch < int'(NCH) && addr < int'(DEP)) bank_m[(ch*DEP+addr)*DW +: DW] = data;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (io.sig_valid === 1'b1) begin
            nvalid++;
            compared++;
            assert (sb.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_sig_valid: observed pulse with sig_out %h expected none",
                       io.sig_out);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sig_out", io.sig_out, e.sig);
                check("sig_count", 64'(io.sig_count), 64'(e.cnt));
                check("latency", 64'(pcyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        io.wr_en = 0; io.wr_ch = '0; io.wr_addr = '0; io.wr_data = '0;
        io.res_valid = 0; io.res_data = '0; io.acc_mode = 0; io.sig_clear = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sig_out", io.sig_out, 64'd0);
        check("rst_sig_count", 64'(io.sig_count), 64'd0);
        check("rst_sig_valid", 64'(io.sig_valid), 64'd0);
        check("rst_addr_err", 64'(io.addr_err), 64'd0);
        check_bank("rst_bank");
        rst_n = 1'b1;

        // Bank load and last-write-wins
        bank_write(1, 5, 64'hDEAD_BEEF_0000_0001);
        @(negedge clk); io.wr_en = 0;
        check_bank("bank_load");
        check("no_addr_err", 64'(io.addr_err), 64'd0);
        bank_write(2, 67, 64'h1111_2222_3333_4444);
        bank_write(2, 67, 64'h5555_6666_7777_8888);
        @(negedge clk); io.wr_en = 0;
        check_bank("bank_last_write");

        // Out-of-range channel, then out-of-range address
        bank_write(3, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk); io.wr_en = 0;
        check("addr_err_ch", 64'(io.addr_err), 64'd1);
        check_bank("oob_ch_bank");
        @(negedge clk);
        check("addr_err_ch_end", 64'(io.addr_err), 64'd0);
        bank_write(0, 68, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk); io.wr_en = 0;
        check("addr_err_addr", 64'(io.addr_err), 64'd1);
        check_bank("oob_addr_bank");
        @(negedge clk);
        check("addr_err_addr_end", 64'(io.addr_err), 64'd0);

        // Plain fold of 1..52
        for (int k = 0; k < int'(NRES); k++) d[k*DW +: DW] = 64'(k + 1);
        @(negedge clk); io.res_valid = 1; io.res_data = d;
        expect_sig(64'h34, 1'b0, 1'b0, pcyc + LAT);
        @(negedge clk); io.res_valid = 0;
        drain("drain_plain");
        check("plain_sig", io.sig_out, 64'h34);

        // Clear alone
        @(negedge clk); io.sig_clear = 1; m_sig = '0; m_cnt = '0;
        n0 = nvalid;
        @(negedge clk); io.sig_clear = 0;
        check("clear_sig", io.sig_out, 64'd0);
        check("clear_cnt", 64'(io.sig_count), 64'd0);
        check("clear_no_valid", 64'(nvalid - n0), 64'd0);

        // Accumulate three back-to-back results
        io.acc_mode = 1;
        d = '0; d[63:0] = 64'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); io.res_valid = 1; io.res_data = d;
            expect_sig(64'h1, 1'b1, 1'b0, pcyc + LAT);
        end
        @(negedge clk); io.res_valid = 0;
        drain("drain_acc");
        check("acc_sig", io.sig_out, 64'h7);
        check("acc_cnt", 64'(io.sig_count), 64'd3);

        // Clear coinciding with a final-stage valid
        d = '0; d[63:0] = 64'hA;
        @(negedge clk); io.res_valid = 1; io.res_data = d;
        expect_sig(64'hA, 1'b1, 1'b1, pcyc + LAT);
        @(negedge clk); io.res_valid = 0;
        repeat (2) @(negedge clk);
        io.sig_clear = 1;
        @(negedge clk); io.sig_clear = 0;
        drain("drain_clr");
        check("clr_coincide_sig", io.sig_out, 64'hA);
        check("clr_coincide_cnt", 64'(io.sig_count), 64'd1);

        // Random back-to-back plain folds
        io.acc_mode = 0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < int'(NRES); k++) d[k*DW +: DW] = {$urandom, $urandom};
            @(negedge clk); io.res_valid = 1; io.res_data = d;
            expect_sig(fold_ref(d), 1'b0, 1'b0, pcyc + LAT);
        end
        @(negedge clk); io.res_valid = 0;
        drain("drain_rand");

        // acc_mode takes effect at the signature stage, not at input
        d = '0; d[64 +: 64] = 64'h5;
        @(negedge clk); io.res_valid = 1; io.res_data = d;
        expect_sig(64'h5, 1'b1, 1'b0, pcyc + LAT);
        @(negedge clk); io.res_valid = 0; io.acc_mode = 1;
        drain("drain_late_acc");
        io.acc_mode = 0;

        // Reset two cycles after a result: nothing may emerge
        n0 = nvalid;
        for (int k = 0; k < int'(NRES); k++) d[k*DW +: DW] = {$urandom, $urandom};
        @(negedge clk); io.res_valid = 1; io.res_data = d;
        @(negedge clk); io.res_valid = 0;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        bank_m = '0; m_sig = '0; m_cnt = '0;
        repeat (6) @(negedge clk);
        check("rst_mid_no_valid", 64'(nvalid - n0), 64'd0);
        check("rst_mid_sig", io.sig_out, 64'd0);
        check("rst_mid_cnt", 64'(io.sig_count), 64'd0);
        check_bank("rst_mid_bank");
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
